// File: rtl/output_unit.sv
// output_unit: per-output switch allocator and link sender for a wormhole router.
// Arbitrates round-robin among input units, grants one of them, handshakes the
// downstream link, then forwards the winner's flits until TAIL or the length limit.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_switch_req        per-port request level from the input units
//   i_flit              per-port flit, port p at [p*FLIT_SIZE +: FLIT_SIZE]
//   o_switch_ack        one-hot grant pulse to the winning input unit
//   o_downstream_req    link request toward the downstream input unit
//   i_transmit_ack      downstream acceptance pulse
//   o_flit              registered flit to downstream
//   o_grant_port        index of the port currently owning the output
//   o_busy              high whenever the FSM is not idle
//   o_len_err           sticky packet-length violation flag
module output_unit #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned FLIT_SIZE = 32,
  parameter int unsigned MAX_FLITS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           i_switch_req,
  input  logic [NUM_PORTS*FLIT_SIZE-1:0] i_flit,
  output logic [NUM_PORTS-1:0]           o_switch_ack,
  output logic                           o_downstream_req,
  input  logic                           i_transmit_ack,
  output logic [FLIT_SIZE-1:0]           o_flit,
  output logic [$clog2(NUM_PORTS)-1:0]   o_grant_port,
  output logic                           o_busy,
  output logic                           o_len_err
);

  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned CW = 8;
  localparam logic [1:0]  T_HEAD = 2'b00;
  localparam logic [1:0]  T_TAIL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_LINK_REQ, S_SEND, S_RELEASE
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_PORTS-1:0]   r_switch_ack, w_switch_ack_nxt;
  logic                   r_downstream_req, w_downstream_req_nxt;
  logic [FLIT_SIZE-1:0]   r_flit, w_flit_nxt;
  logic [GW-1:0]          r_grant_port, w_grant_port_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_len_err, w_len_err_nxt;
  logic [GW-1:0]          r_last_grant, w_last_grant_nxt;
  logic [CW-1:0]          r_flit_cnt, w_flit_cnt_nxt;

  logic [GW-1:0]          w_rr_idx;
  logic [GW-1:0]          w_rr_winner;
  logic                   w_rr_found;
  logic [FLIT_SIZE-1:0]   w_sel_flit;
  logic                   w_sel_valid;
  logic [1:0]             w_sel_type;
  logic [CW-1:0]          w_cnt_inc;
  logic                   w_at_max;

  // Round-robin search starting just above the last granted port.
  always_comb begin
    w_rr_found  = 1'b0;
    w_rr_winner = r_last_grant;
    w_rr_idx    = r_last_grant;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      w_rr_idx = GW'((32'(r_last_grant) + i) % NUM_PORTS);
      if (!w_rr_found && i_switch_req[w_rr_idx]) begin
        w_rr_found  = 1'b1;
        w_rr_winner = w_rr_idx;
      end
    end
  end

  // Flit of the port that currently owns the output.
  assign w_sel_flit  = i_flit[32'(r_grant_port)*FLIT_SIZE +: FLIT_SIZE];
  assign w_sel_valid = w_sel_flit[FLIT_SIZE-1];
  assign w_sel_type  = w_sel_flit[FLIT_SIZE-2 -: 2];
  assign w_cnt_inc   = r_flit_cnt + CW'(1);
  assign w_at_max    = (32'(w_cnt_inc) >= MAX_FLITS);

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    w_state_nxt          = r_state;
    w_switch_ack_nxt     = '0;
    w_downstream_req_nxt = 1'b0;
    w_flit_nxt           = '0;
    w_grant_port_nxt     = r_grant_port;
    w_len_err_nxt        = r_len_err;
    w_last_grant_nxt     = r_last_grant;
    w_flit_cnt_nxt       = r_flit_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_rr_found) begin
          w_grant_port_nxt = w_rr_winner;
          w_switch_ack_nxt = NUM_PORTS'(1) << w_rr_winner;
          w_state_nxt      = S_GRANT;
        end
      end
      S_GRANT: begin
        w_downstream_req_nxt = 1'b1;
        w_state_nxt          = S_LINK_REQ;
      end
      S_LINK_REQ: begin
        if (i_transmit_ack) begin
          w_flit_cnt_nxt = '0;
          w_state_nxt    = S_SEND;
        end else begin
          w_downstream_req_nxt = 1'b1;
        end
      end
      S_SEND: begin
        if (w_sel_valid) begin
          w_flit_nxt     = w_sel_flit;
          w_flit_cnt_nxt = w_cnt_inc;
          if (w_sel_type == T_TAIL) begin
            w_state_nxt = S_RELEASE;
          end else begin
            // A HEAD after the first counted flit means the packet lost its TAIL.
            if ((w_sel_type == T_HEAD) && (r_flit_cnt != '0)) begin
              w_len_err_nxt = 1'b1;
            end
            // Length limit reached: close the packet by forcing a TAIL.
            if (w_at_max) begin
              w_flit_nxt[FLIT_SIZE-2 -: 2] = T_TAIL;
              w_len_err_nxt                = 1'b1;
              w_state_nxt                  = S_RELEASE;
            end
          end
        end
      end
      S_RELEASE: begin
        w_last_grant_nxt = r_grant_port;
        w_state_nxt      = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_switch_ack     <= '0;
      r_downstream_req <= 1'b0;
      r_flit           <= '0;
      r_grant_port     <= '0;
      r_busy           <= 1'b0;
      r_len_err        <= 1'b0;
      r_last_grant     <= GW'(NUM_PORTS - 1);
      r_flit_cnt       <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_switch_ack     <= w_switch_ack_nxt;
      r_downstream_req <= w_downstream_req_nxt;
      r_flit           <= w_flit_nxt;
      r_grant_port     <= w_grant_port_nxt;
      r_busy           <= w_busy_nxt;
      r_len_err        <= w_len_err_nxt;
      r_last_grant     <= w_last_grant_nxt;
      r_flit_cnt       <= w_flit_cnt_nxt;
    end
  end

  assign o_switch_ack     = r_switch_ack;
  assign o_downstream_req = r_downstream_req;
  assign o_flit           = r_flit;
  assign o_grant_port     = r_grant_port;
  assign o_busy           = r_busy;
  assign o_len_err        = r_len_err;

endmodule

// File: tb/tb_output_unit.sv
// tb_output_unit: directed self-checking bench for output_unit (5 ports, 32-bit flits,
// packet limit of 4 flits so the over-length path is reachable with short packets).
module tb_output_unit;

  localparam int unsigned NP = 5;
  localparam int unsigned FS = 32;
  localparam int unsigned MF = 4;
  localparam logic [1:0]  HEAD = 2'b00;
  localparam logic [1:0]  BODY = 2'b01;
  localparam logic [1:0]  TAIL = 2'b10;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    i_switch_req;
  logic [NP*FS-1:0] i_flit;
  logic [NP-1:0]    o_switch_ack;
  logic             o_downstream_req;
  logic             i_transmit_ack;
  logic [FS-1:0]    o_flit;
  logic [2:0]       o_grant_port;
  logic             o_busy;
  logic             o_len_err;

  int n_checks = 0;
  int n_fail   = 0;

  output_unit #(.NUM_PORTS(NP), .FLIT_SIZE(FS), .MAX_FLITS(MF)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_switch_req     (i_switch_req),
    .i_flit           (i_flit),
    .o_switch_ack     (o_switch_ack),
    .o_downstream_req (o_downstream_req),
    .i_transmit_ack   (i_transmit_ack),
    .o_flit           (o_flit),
    .o_grant_port     (o_grant_port),
    .o_busy           (o_busy),
    .o_len_err        (o_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [28:0] p);
    return {1'b1, t, p};
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [FS-1:0] f);
    i_flit[p*FS +: FS] = f;
  endtask

  // From GRANT: one LINK_REQ cycle, then ack so the FSM is in SEND afterwards.
  task automatic link_up();
    step();
    i_transmit_ack = 1'b1;
    step();
    i_transmit_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_switch_req = '0;
    i_transmit_ack = 1'b0;
    i_flit = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_switch_ack !== 5'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 00000", o_switch_ack); end
    n_checks++; if (o_downstream_req !== 1'b0) begin n_fail++; $display("FAIL reset_dreq: got %b expected 0", o_downstream_req); end
    n_checks++; if (o_flit !== 32'h0) begin n_fail++; $display("FAIL reset_flit: got %h expected 0", o_flit); end
    n_checks++; if (o_grant_port !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", o_grant_port); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b expected 0", o_len_err); end
  endtask

  task automatic test_single();
    logic [FS-1:0] pkt [3];
    pkt[0] = mk(HEAD, 29'h0000_0a1); pkt[1] = mk(BODY, 29'h0000_0b2); pkt[2] = mk(TAIL, 29'h0000_0c3);
    for (int p = 0; p < int'(NP); p++) set_port(p, mk(HEAD, 29'h0bad));
    i_switch_req = 5'b00100;
    step();
    n_checks++; if (o_switch_ack !== 5'b00100) begin n_fail++; $display("FAIL single_ack: got %b expected 00100", o_switch_ack); end
    n_checks++; if (o_grant_port !== 3'd2) begin n_fail++; $display("FAIL single_grant: got %0d expected 2", o_grant_port); end
    n_checks++; if (o_downstream_req !== 1'b0) begin n_fail++; $display("FAIL single_dreq_early: got %b expected 0", o_downstream_req); end
    i_switch_req = '0;
    step();
    n_checks++; if (o_switch_ack !== 5'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 00000", o_switch_ack); end
    n_checks++; if (o_downstream_req !== 1'b1) begin n_fail++; $display("FAIL single_dreq1: got %b expected 1", o_downstream_req); end
    step();
    n_checks++; if (o_downstream_req !== 1'b1) begin n_fail++; $display("FAIL single_dreq2: got %b expected 1", o_downstream_req); end
    i_transmit_ack = 1'b1;
    step();
    i_transmit_ack = 1'b0;
    n_checks++; if (o_downstream_req !== 1'b0) begin n_fail++; $display("FAIL single_dreq_drop: got %b expected 0", o_downstream_req); end
    for (int k = 0; k < 3; k++) begin
      set_port(2, pkt[k]);
      step();
      n_checks++; if (o_flit !== pkt[k]) begin n_fail++; $display("FAIL single_flit%0d: got %h expected %h", k, o_flit, pkt[k]); end
    end
    i_flit = '0;
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy got %b expected 0", o_busy); end
    n_checks++; if (o_flit !== 32'h0) begin n_fail++; $display("FAIL single_release_flit: got %h expected 0", o_flit); end
    n_checks++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL single_len_err: got %b expected 0", o_len_err); end
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 1, 4, 0, 1, 4};
    logic [NP-1:0] exp_ack;
    do_reset();
    i_switch_req = 5'b10011;
    for (int n = 0; n < 6; n++) begin
      exp_ack = NP'(1) << order[n];
      step();
      n_checks++; if (o_switch_ack !== exp_ack) begin n_fail++; $display("FAIL fair_ack%0d: got %b expected %b", n, o_switch_ack, exp_ack); end
      n_checks++; if (o_grant_port !== 3'(order[n])) begin n_fail++; $display("FAIL fair_grant%0d: got %0d expected %0d", n, o_grant_port, order[n]); end
      link_up();
      for (int p = 0; p < int'(NP); p++) set_port(p, mk(TAIL, 29'(p)));
      step();
      n_checks++; if (o_flit !== mk(TAIL, 29'(order[n]))) begin n_fail++; $display("FAIL fair_flit%0d: got %h expected %h", n, o_flit, mk(TAIL, 29'(order[n]))); end
      i_flit = '0;
      step();
    end
    i_switch_req = '0;
  endtask

  task automatic test_bubbles();
    logic [FS-1:0] drv [5];
    logic [FS-1:0] exp [5];
    drv[0] = mk(HEAD, 29'h11); drv[1] = 32'h1234_5678; drv[2] = mk(BODY, 29'h22);
    drv[3] = 32'h7fff_ffff;    drv[4] = mk(TAIL, 29'h33);
    exp[0] = drv[0]; exp[1] = '0; exp[2] = drv[2]; exp[3] = '0; exp[4] = drv[4];
    i_switch_req = 5'b01000;
    step();
    n_checks++; if (o_grant_port !== 3'd3) begin n_fail++; $display("FAIL bub_grant: got %0d expected 3", o_grant_port); end
    i_switch_req = '0;
    link_up();
    for (int k = 0; k < 5; k++) begin
      set_port(3, drv[k]);
      step();
      n_checks++; if (o_flit !== exp[k]) begin n_fail++; $display("FAIL bub_flit%0d: got %h expected %h", k, o_flit, exp[k]); end
    end
    i_flit = '0;
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bub_idle: busy got %b expected 0", o_busy); end
    n_checks++; if (dut.r_flit_cnt !== 8'd3) begin n_fail++; $display("FAIL bub_count: got %0d expected 3", dut.r_flit_cnt); end
    n_checks++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL bub_len_err: got %b expected 0", o_len_err); end
  endtask

  task automatic test_stall();
    i_switch_req = 5'b00001;
    step();
    n_checks++; if (o_switch_ack !== 5'b00001) begin n_fail++; $display("FAIL stall_ack: got %b expected 00001", o_switch_ack); end
    i_switch_req = '0;
    set_port(0, mk(HEAD, 29'h55));
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++; if (o_downstream_req !== 1'b1) begin n_fail++; $display("FAIL stall_dreq%0d: got %b expected 1", k, o_downstream_req); end
      n_checks++; if (o_flit !== 32'h0) begin n_fail++; $display("FAIL stall_flit%0d: got %h expected 0", k, o_flit); end
    end
    i_transmit_ack = 1'b1;
    step();
    n_checks++; if (o_downstream_req !== 1'b0) begin n_fail++; $display("FAIL stall_dreq_drop: got %b expected 0", o_downstream_req); end
    set_port(0, mk(TAIL, 29'h66));
    step();
    n_checks++; if (o_flit !== mk(TAIL, 29'h66)) begin n_fail++; $display("FAIL stall_tail: got %h expected %h", o_flit, mk(TAIL, 29'h66)); end
    n_checks++; if (o_downstream_req !== 1'b0) begin n_fail++; $display("FAIL stall_stray_ack: dreq got %b expected 0", o_downstream_req); end
    i_flit = '0;
    step();
    i_transmit_ack = 1'b0;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle: busy got %b expected 0", o_busy); end
    n_checks++; if (o_downstream_req !== 1'b0) begin n_fail++; $display("FAIL stall_idle_dreq: got %b expected 0", o_downstream_req); end
  endtask

  task automatic test_overlen();
    logic [FS-1:0] drv [6];
    logic [FS-1:0] exp [4];
    drv[0] = mk(HEAD, 29'h40);
    for (int k = 1; k < 6; k++) drv[k] = mk(BODY, 29'(32'h40 + k));
    exp[0] = drv[0]; exp[1] = drv[1]; exp[2] = drv[2]; exp[3] = mk(TAIL, 29'h43);
    i_switch_req = 5'b00010;
    step();
    n_checks++; if (o_grant_port !== 3'd1) begin n_fail++; $display("FAIL ovl_grant: got %0d expected 1", o_grant_port); end
    i_switch_req = '0;
    link_up();
    for (int k = 0; k < 4; k++) begin
      set_port(1, drv[k]);
      step();
      n_checks++; if (o_flit !== exp[k]) begin n_fail++; $display("FAIL ovl_flit%0d: got %h expected %h", k, o_flit, exp[k]); end
      if (k == 2) begin
        n_checks++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL ovl_err_early: got %b expected 0", o_len_err); end
      end
    end
    n_checks++; if (o_len_err !== 1'b1) begin n_fail++; $display("FAIL ovl_err_set: got %b expected 1", o_len_err); end
    set_port(1, drv[4]);
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ovl_idle: busy got %b expected 0", o_busy); end
    n_checks++; if (o_flit !== 32'h0) begin n_fail++; $display("FAIL ovl_release_flit: got %h expected 0", o_flit); end
    set_port(1, drv[5]);
    step();
    n_checks++; if (o_len_err !== 1'b1) begin n_fail++; $display("FAIL ovl_err_sticky: got %b expected 1", o_len_err); end
    n_checks++; if (o_switch_ack !== 5'b0) begin n_fail++; $display("FAIL ovl_no_ack: got %b expected 00000", o_switch_ack); end
    i_flit = '0;
  endtask

  task automatic test_reset_mid();
    i_switch_req = 5'b01001;
    step();
    n_checks++; if (o_grant_port !== 3'd3) begin n_fail++; $display("FAIL rmid_grant: got %0d expected 3", o_grant_port); end
    i_switch_req = 5'b00001;
    link_up();
    set_port(3, mk(HEAD, 29'h70));
    step();
    set_port(3, mk(BODY, 29'h71));
    step();
    n_checks++; if (o_flit !== mk(BODY, 29'h71)) begin n_fail++; $display("FAIL rmid_flit: got %h expected %h", o_flit, mk(BODY, 29'h71)); end
    set_port(3, mk(TAIL, 29'h72));
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (o_flit !== 32'h0) begin n_fail++; $display("FAIL rmid_flit0: got %h expected 0", o_flit); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_downstream_req !== 1'b0) begin n_fail++; $display("FAIL rmid_dreq: got %b expected 0", o_downstream_req); end
    n_checks++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL rmid_len_err: got %b expected 0", o_len_err); end
    n_checks++; if (o_grant_port !== 3'd0) begin n_fail++; $display("FAIL rmid_grant0: got %0d expected 0", o_grant_port); end
    i_switch_req = 5'b01001;
    step();
    n_checks++; if (o_switch_ack !== 5'b00001) begin n_fail++; $display("FAIL rmid_regrant: got %b expected 00001", o_switch_ack); end
    i_switch_req = '0;
    step();
    n_checks++; if (o_downstream_req !== 1'b1) begin n_fail++; $display("FAIL rmid_dreq_new: got %b expected 1", o_downstream_req); end
  endtask

  task automatic test_head_mid();
    do_reset();
    i_switch_req = 5'b00100;
    step();
    i_switch_req = '0;
    link_up();
    set_port(2, mk(HEAD, 29'h90));
    step();
    n_checks++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL hmid_first_head: err got %b expected 0", o_len_err); end
    set_port(2, mk(HEAD, 29'h91));
    step();
    n_checks++; if (o_flit !== mk(HEAD, 29'h91)) begin n_fail++; $display("FAIL hmid_flit: got %h expected %h", o_flit, mk(HEAD, 29'h91)); end
    n_checks++; if (o_len_err !== 1'b1) begin n_fail++; $display("FAIL hmid_err: got %b expected 1", o_len_err); end
    set_port(2, mk(TAIL, 29'h92));
    step();
    i_flit = '0;
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL hmid_idle: busy got %b expected 0", o_busy); end
  endtask

  initial begin
    reset = 1'b1;
    i_switch_req = '0;
    i_transmit_ack = 1'b0;
    i_flit = '0;
    test_reset();
    test_single();
    test_fairness();
    test_bubbles();
    test_stall();
    test_overlen();
    test_reset_mid();
    test_head_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_unit.md
OUTPUT_UNIT -- requirements
Module: output_unit

Interface
REQ-001 Parameter NUM_PORTS, default 5: number of input units competing for this output.
REQ-002 Parameter FLIT_SIZE, default 32: flit width; bit FLIT_SIZE-1 = valid; bits [FLIT_SIZE-2:FLIT_SIZE-3] = type (00 HEAD, 01 BODY, 10 TAIL, 11 reserved).
REQ-003 Parameter MAX_FLITS, default 16: maximum flits per packet, HEAD and TAIL included.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_switch_req  input  NUM_PORTS  per-port request from an input unit; level, held until acked.
REQ-007 i_flit  input  NUM_PORTS*FLIT_SIZE  per-port flit; port p occupies bits [p*FLIT_SIZE +: FLIT_SIZE].
REQ-008 o_switch_ack  output  NUM_PORTS  one-hot grant pulse to the winning input unit.
REQ-009 o_downstream_req  output  1  link request to the downstream input unit.
REQ-010 i_transmit_ack  input  1  downstream acceptance, 1-cycle pulse.
REQ-011 o_flit  output  FLIT_SIZE  registered flit to downstream.
REQ-012 o_grant_port  output  $clog2(NUM_PORTS)  index of the port currently owning the output.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_len_err  output  1  sticky packet-length violation flag.

Function
REQ-015 FSM states IDLE, GRANT, LINK_REQ, SEND, RELEASE, encoded in one registered state variable.
REQ-016 IDLE: when any i_switch_req bit is high, select the winner round-robin, searching upward from (last_grant+1) mod NUM_PORTS; register it into o_grant_port; go to GRANT.
REQ-017 GRANT: drive o_switch_ack one-hot for the registered port for exactly this one cycle; go to LINK_REQ.
REQ-018 LINK_REQ: hold o_downstream_req=1 every cycle until i_transmit_ack=1 is sampled; then go to SEND, with o_downstream_req=0 from the next cycle.
REQ-019 An i_transmit_ack sampled in any state other than LINK_REQ is ignored.
REQ-020 SEND: each cycle, register i_flit of the granted port into o_flit when its valid bit is 1; otherwise register all-zero. Invalid cycles are bubbles and are not counted.
REQ-021 SEND: an 8-bit flit counter clears on entry and increments per valid flit forwarded.
REQ-022 A valid flit of type TAIL moves the FSM to RELEASE.
REQ-023 If the counter reaches MAX_FLITS with no TAIL seen:
 - the flit forwarded in that cycle has its type forced to TAIL;
 - o_len_err is set;
 - the FSM moves to RELEASE.
REQ-024 A HEAD flit received in SEND after the first counted flit sets o_len_err and is forwarded unchanged.
REQ-025 RELEASE: set last_grant to o_grant_port, drive o_flit to zero, return to IDLE. Minimum request-to-request gap is therefore one idle cycle.
REQ-026 Requests that rise while the FSM is not in IDLE are ignored until the next IDLE arbitration.
REQ-027 A requester that drops i_switch_req before GRANT is still granted; no retraction is supported.
REQ-028 o_switch_ack is never multi-hot and is zero outside GRANT.
REQ-029 Latency: request seen in IDLE at cycle t -> ack at t+1 -> o_downstream_req first high at t+2.

Reset
REQ-030 reset=1 at a clock edge forces, from the next cycle:
 - state IDLE;
 - o_switch_ack, o_downstream_req, o_flit, o_grant_port and o_len_err to 0;
 - o_busy to 0;
 - last_grant to NUM_PORTS-1, so port 0 has first priority;
 - flit counter to 0.
REQ-031 Reset asserted mid-packet abandons the packet: no TAIL is emitted and o_downstream_req drops at once.

Verification
REQ-032 Single requester: port 2 requests, ack on the 2nd cycle of o_downstream_req, packet HEAD,BODY,TAIL -> o_switch_ack=5'b00100 for one cycle; the three flits appear on o_flit in order, one cycle after input; FSM back in IDLE, o_len_err=0.
REQ-033 Fairness: ports 0,1,4 request continuously from reset -> grant order 0,1,4,0,1,4; no port granted twice while another waits.
REQ-034 Bubbles: HEAD, invalid, BODY, invalid, TAIL on the granted port -> o_flit shows zeros in the bubble cycles; counter ends at 3; no error.
REQ-035 Over-length: MAX_FLITS=4, packet of HEAD + 5 BODY -> 4th forwarded flit has type 10; o_len_err=1 and stays 1; return to IDLE.
REQ-036 Stalled link: i_transmit_ack withheld for 20 cycles -> o_downstream_req high all 20 cycles; no flit forwarded; a stray ack pulsed during SEND has no effect.
REQ-037 Reset mid-SEND after 2 flits -> next cycle all outputs 0, state IDLE; a new port-0 request is granted first.
